// File: rtl/uart_alu_interface_pkg.sv
// uart_alu_interface_pkg: shared state encodings and default widths for the UART/ALU datapath.
package uart_alu_interface_pkg;
  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF = 6;
  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    CALC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;
endpackage

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: assembles A/B/op frames from the UART receiver and forwards the ALU result to the transmitter.
module uart_alu_interface
  import uart_alu_interface_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_OP = NB_OP_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_overrun
);
  state_t state, state_next;
  logic [NB_DATA-1:0] data_a_next, data_b_next, tx_data_next;
  logic [NB_OP-1:0] op_next;
  logic tx_start_next, overrun_next;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= WAIT_A;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_next;
      o_data_a   <= data_a_next;
      o_data_b   <= data_b_next;
      o_op       <= op_next;
      o_tx_data  <= tx_data_next;
      o_tx_start <= tx_start_next;
      o_overrun  <= overrun_next;
    end
  end
  always_comb begin
    state_next = WAIT_A;
    case (state)
      WAIT_A:  state_next = i_rx_done ? WAIT_B : WAIT_A;
      WAIT_B:  state_next = i_rx_done ? WAIT_OP : WAIT_B;
      WAIT_OP: state_next = i_rx_done ? CALC : WAIT_OP;
      CALC:    state_next = SEND;
      SEND:    state_next = WAIT_TX;
      WAIT_TX: state_next = i_tx_done ? WAIT_A : WAIT_TX;
      default: state_next = WAIT_A;
    endcase
  end
  // Bytes arriving while a result is still in flight are dropped and flagged.
  always_comb begin
    data_a_next   = (state == WAIT_A && i_rx_done) ? i_data : o_data_a;
    data_b_next   = (state == WAIT_B && i_rx_done) ? i_data : o_data_b;
    op_next       = (state == WAIT_OP && i_rx_done) ? i_data[NB_OP-1:0] : o_op;
    tx_data_next  = (state == CALC) ? i_alu_result : o_tx_data;
    tx_start_next = (state == CALC);
    overrun_next  = i_rx_done && (state inside {CALC, SEND, WAIT_TX});
  end
endmodule

// File: tb/tb_uart_alu_interface.sv
// tb_uart_alu_interface: randomized frames against a frame-level reference model with a scoreboard monitor.
module tb_uart_alu_interface;
  logic clk = 0, rst = 1, rx_done = 0, tx_done = 0;
  logic [7:0] data = 0, alu_result, data_a, data_b, tx_data;
  logic [5:0] op;
  logic tx_start, overrun;
  typedef struct {
    logic [7:0] a, b, res;
    logic [5:0] op;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, total = 0, passed = 0, exp_ovr = 0, obs_ovr = 0, last_start = -10;
  always #5 clk = ~clk;
  uart_alu_interface dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_rx_done(rx_done),
    .i_alu_result(alu_result), .i_tx_done(tx_done),
    .o_data_a(data_a), .o_data_b(data_b), .o_op(op),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .o_overrun(overrun)
  );
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] o);
    case (o)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return 8'($signed(a) >>> b[2:0]);
      6'h02: return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction
  assign alu_result = alu(data_a, data_b, op);
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (overrun) obs_ovr++;
    if (cyc == last_start + 1) chk("tx_start_one_cycle", int'(tx_start), 0);
    if (tx_start) begin
      if (sb.size() == 0) chk("unexpected_tx_start", 1, 0);
      else begin
        e = sb.pop_front();
        chk("data_a", int'(data_a), int'(e.a));
        chk("data_b", int'(data_b), int'(e.b));
        chk("op", int'(op), int'(e.op));
        chk("tx_data", int'(tx_data), int'(e.res));
        chk("tx_start_latency", cyc, e.cyc);
      end
      last_start = cyc;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tx_done = 1'($urandom_range(0, 1));
      tick();
      tx_done = 0;
    end
  endtask
  task automatic send(input logic [7:0] b);
    data = b;
    rx_done = 1;
    tick();
    rx_done = 0;
    data = 8'($urandom);
  endtask
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob,
                       input int n_extra, input bit dup, input bit gaps);
    int idl, kk;
    exp_t e;
    send(a);
    idle(gaps ? $urandom_range(0, 2) : 0);
    send(b);
    idle(gaps ? $urandom_range(0, 2) : 0);
    e.a = a; e.b = b; e.op = ob[5:0]; e.res = alu(a, b, ob[5:0]); e.cyc = cyc + 2;
    sb.push_back(e);
    send(ob);
    idl = $urandom_range(0, 2);
    kk = (n_extra + 1 + idl > 3) ? n_extra + 1 + idl : 3;
    for (int k = 1; k <= kk; k++) begin
      if (k <= n_extra) begin
        rx_done = 1; data = 8'($urandom); exp_ovr++;
      end
      if (k == kk) begin
        tx_done = 1;
        if (dup) begin
          rx_done = 1; data = 8'hAA; exp_ovr++;
        end
      end
      tick();
      rx_done = 0; tx_done = 0;
    end
  endtask
  initial begin
    logic [7:0] ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    #3;
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_data_b", int'(data_b), 0);
    chk("rst_op", int'(op), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_overrun", int'(overrun), 0);
    #9 rst = 0;
    tick();
    frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
    frame(8'h40, 8'h11, 8'hE2, 0, 0, 1);
    frame(8'h12, 8'h34, 8'h25, 1, 0, 0);
    frame(8'h10, 8'h01, 8'h22, 0, 1, 0);
    frame(8'h10, 8'h01, 8'h22, 0, 0, 0);
    send(8'h7F);
    chk("mid_frame_a", int'(data_a), 8'h7F);
    #2 rst = 1;
    #1;
    chk("async_rst_data_a", int'(data_a), 0);
    #2 rst = 0;
    tick();
    frame(8'h0F, 8'hF0, 8'h26, 0, 0, 1);
    send(8'h33);
    send(8'h44);
    send(8'h20);
    tick();
    chk("send_tx_start", int'(tx_start), 1);
    #1 rst = 1;
    #1;
    chk("rst_in_send_tx_start", int'(tx_start), 0);
    chk("rst_in_send_tx_data", int'(tx_data), 0);
    chk("rst_in_send_op", int'(op), 0);
    #2 rst = 0;
    tick();
    frame(8'h81, 8'h02, 8'h03, 0, 0, 0);
    frame(8'h81, 8'h02, 8'h02, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      frame(8'($urandom), 8'($urandom), {2'($urandom), ops[$urandom_range(0, 7)][5:0]},
            $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1);
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    chk("overrun_count", obs_ovr, exp_ovr);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Consumes bytes from the upstream UART receiver, one per single-cycle done pulse.
- Assembles each 3-byte command frame (operand A, operand B, opcode) and drives them to the combinational ALU.
- Captures the ALU result and hands it to the UART transmitter with a start/done handshake.
- Sits between the receiver and the ALU/transmitter pair in the top-level system.

Parameters:
- NB_DATA, 8: operand, result and received byte width.
- NB_OP, 6: opcode width; the low NB_OP bits of the third byte are used.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset
- i_data  input  NB_DATA  received byte from the UART receiver (data bits only, no carry bit)
- i_rx_done  input  1  one-cycle pulse; i_data is valid in that cycle
- i_alu_result  input  NB_DATA  combinational ALU output
- i_tx_done  input  1  one-cycle pulse from the transmitter when the frame has been sent
- o_data_a  output  NB_DATA  operand A to the ALU
- o_data_b  output  NB_DATA  operand B to the ALU
- o_op  output  NB_OP  opcode to the ALU
- o_tx_data  output  NB_DATA  byte to transmit
- o_tx_start  output  1  one-cycle transmit request
- o_overrun  output  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset: i_rst is asynchronous and active-high; clock is i_clk. On reset, state = WAIT_A and all outputs are 0.
- All outputs are registered. No combinational path exists from any input to any output.
- State WAIT_A: on i_rx_done, o_data_a <= i_data, go to WAIT_B. Otherwise hold.
- State WAIT_B: on i_rx_done, o_data_b <= i_data, go to WAIT_OP.
- State WAIT_OP: on i_rx_done, o_op <= i_data[NB_OP-1:0], go to CALC. Upper bits are discarded.
- State CALC: one cycle for the ALU to settle with the new operands. Unconditionally:
  - o_tx_data <= i_alu_result
  - o_tx_start <= 1
  - go to SEND
- State SEND: o_tx_start is high for exactly this one cycle. Next edge: o_tx_start <= 0, go to WAIT_TX.
- State WAIT_TX: on i_tx_done, go to WAIT_A. o_data_a, o_data_b and o_op hold their values until overwritten by the next frame.
- Latency: op-byte i_rx_done sampled at edge t.
  - o_op valid after t.
  - o_tx_data valid and o_tx_start high after t+1.
  - o_tx_start low again after t+2.
- Overrun: i_rx_done in CALC, SEND or WAIT_TX drops the byte and pulses o_overrun for one cycle (registered, next edge). State and data are unaffected.
- o_overrun is never asserted in WAIT_A, WAIT_B or WAIT_OP.
- i_tx_done outside WAIT_TX is ignored.
- i_tx_done and i_rx_done in the same WAIT_TX cycle: the transition to WAIT_A wins, the byte is dropped, and o_overrun pulses.
- There is no frame timeout. A partial frame waits indefinitely; only reset resynchronises.
- Reset mid-frame or mid-transmit returns to WAIT_A with all outputs cleared, including o_tx_start if it was high.
- State register is 3 bits. The six encodings are used; unused encodings recover to WAIT_A.

Decomposition:
- Shared package holds:
  - state encodings (WAIT_A=0, WAIT_B=1, WAIT_OP=2, CALC=3, SEND=4, WAIT_TX=5)
  - default NB_DATA/NB_OP constants shared with the receiver, transmitter and ALU.
- No sub-module. Single FSM with a next-state/next-output always block and a registered update block.

Test Plan:
- Frame 0x05, 0x03, 0x20 with the ALU model computing ADD -> o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_data=0x08; o_tx_start high exactly one cycle, two edges after the op pulse.
- Op byte 0xE2 -> o_op=0x22. Upper bits dropped, no error flag.
- Extra i_rx_done (0xAA) during WAIT_TX -> o_overrun single pulse, state stays WAIT_TX; then i_tx_done -> WAIT_A. Next frame 0x10, 0x01, 0x22 processes normally.
- Reset asserted after operand A 0x7F is received -> o_data_a=0 immediately (async). Next three bytes form a complete new frame.
- Two back-to-back frames, each separated only by i_tx_done -> two o_tx_start pulses with correct results; o_overrun stays 0.
- i_tx_done pulsed in WAIT_B -> ignored. The frame completes normally.
